// File: rtl/rr_arbiter_n_if.sv
// Bus bundle for rr_arbiter_n: request vector in, registered grant/owner/timeout out.
interface rr_arbiter_n_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            timeout;

  modport master (output req, input gnt, gnt_valid, gnt_id, timeout);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant hold; optional forced rotation after MAX_HOLD
// cycles when RR_HOLD_TIMEOUT_EN is defined.
module rr_arbiter_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_n_if.slave bus
);
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    gnt_q, gnt_d;
  logic            valid_q;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            held_c, force_c, found_c;
  logic [N-1:0]    cand_c;
  logic [ID_W-1:0] win_c;
  int unsigned     idx;

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);
  logic [HC_W-1:0] hold_q, hold_d;
  logic            to_q, to_d;
`endif

  // Next grant: hold the owner, otherwise scan circularly from last_id+1.
  always_comb begin
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    held_c  = |(bus.req & gnt_q);
    force_c = 1'b0;
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
`ifdef RR_HOLD_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
    force_c = held_c && (hold_q == HC_W'(MAX_HOLD - 1)) && (|(bus.req & ~gnt_q));
`endif
    // A forced rotation excludes the current owner from the scan.
    cand_c = force_c ? (bus.req & ~gnt_q) : bus.req;

    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_q) + i) % N;
      if (!found_c && cand_c[idx]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx);
      end
    end

    if (held_c && !force_c) begin
`ifdef RR_HOLD_TIMEOUT_EN
      if (hold_q != HC_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
`endif
    end else if (found_c) begin
      gnt_d  = N'(1) << win_c;
      id_d   = win_c;
      last_d = win_c;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_d = '0;
      to_d   = force_c;
`endif
    end else begin
      gnt_d = '0;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N - 1);
`ifdef RR_HOLD_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      gnt_q   <= gnt_d;
      valid_q <= |gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = id_q;
`ifdef RR_HOLD_TIMEOUT_EN
  assign bus.timeout   = to_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: N=4 and N=5 instances against a cycle-level reference model.
module tb_rr_arbiter_n;
  localparam int MAX_HOLD = 4;
`ifdef RR_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int owner;
    int last;
    int id;
    int hcnt;
    bit to;
  } mstate_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   failed = 0;
  mstate_t m4, m5;

  rr_arbiter_n_if #(.N(4)) bus4 ();
  rr_arbiter_n_if #(.N(5)) bus5 ();

  rr_arbiter_n #(.N(4), .MAX_HOLD(MAX_HOLD)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_arbiter_n #(.N(5), .MAX_HOLD(MAX_HOLD)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  always #5 clk = ~clk;

  function automatic bit bitof(int unsigned v, int b);
    return ((v >> b) & 1) != 0;
  endfunction

  // Reference: owner keeps bus while requesting; otherwise first requester after last owner.
  function automatic mstate_t model_next(mstate_t s, int n, int unsigned r, bit rs);
    mstate_t t;
    bit held, forced, found;
    int c;
    t = s;
    t.to = 1'b0;
    if (rs) begin
      t.owner = -1; t.last = n - 1; t.id = 0; t.hcnt = 0;
      return t;
    end
    held   = (s.owner >= 0) && bitof(r, s.owner);
    forced = TO_EN && held && (s.hcnt == MAX_HOLD - 1) &&
             ((r & ~(32'd1 << s.owner) & ((32'd1 << n) - 1)) != 0);
    if (held && !forced) begin
      if (s.hcnt < MAX_HOLD) t.hcnt = s.hcnt + 1;
      return t;
    end
    found = 1'b0;
    for (int k = 1; k <= n; k++) begin
      c = (s.last + k) % n;
      if (!found && bitof(r, c) && !(forced && c == s.owner)) begin
        found = 1'b1;
        t.owner = c; t.last = c; t.id = c; t.hcnt = 0; t.to = forced;
      end
    end
    if (!found) begin
      t.owner = -1; t.hcnt = 0;
    end
    return t;
  endfunction

  function automatic int unsigned exp_gnt(mstate_t s);
    return (s.owner >= 0) ? (32'd1 << s.owner) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input logic [3:0] r4, input logic [4:0] r5, input logic rs);
    bus4.req = r4;
    bus5.req = r5;
    rst = rs;
    @(posedge clk);
    m4 = model_next(m4, 4, 32'(r4), rs);
    m5 = model_next(m5, 5, 32'(r5), rs);
    #1;
    chk("gnt4",   32'(bus4.gnt),       exp_gnt(m4));
    chk("valid4", 32'(bus4.gnt_valid), 32'(m4.owner >= 0));
    chk("id4",    32'(bus4.gnt_id),    32'(m4.id));
    chk("to4",    32'(bus4.timeout),   32'(m4.to));
    chk("oh4",    32'($onehot0(bus4.gnt)), 32'd1);
    chk("qual4",  32'(bus4.gnt & ~r4), 32'd0);
    chk("gnt5",   32'(bus5.gnt),       exp_gnt(m5));
    chk("valid5", 32'(bus5.gnt_valid), 32'(m5.owner >= 0));
    chk("id5",    32'(bus5.gnt_id),    32'(m5.id));
    chk("to5",    32'(bus5.timeout),   32'(m5.to));
    chk("oh5",    32'($onehot0(bus5.gnt)), 32'd1);
    chk("qual5",  32'(bus5.gnt & ~r5), 32'd0);
  endtask

  // N=5 stimulus: everyone requests except the current owner, forcing a rotation each cycle.
  function automatic logic [4:0] rot5(mstate_t s);
    logic [4:0] v;
    v = 5'h1F;
    if (s.owner >= 0) v[s.owner] = 1'b0;
    return v;
  endfunction

  initial begin
    logic [3:0] r4;
    logic [4:0] r5;
    bit rs;
    int ids5[$];

    m4 = '{owner: -1, last: 3, id: 0, hcnt: 0, to: 1'b0};
    m5 = '{owner: -1, last: 4, id: 0, hcnt: 0, to: 1'b0};
    bus4.req = '0; bus5.req = '0; rst = 1'b1;
    @(posedge clk); #1;

    cycle(4'b0000, 5'b00000, 1'b1);
    chk("rst_gnt", 32'(bus4.gnt), 32'd0);
    chk("rst_id",  32'(bus4.gnt_id), 32'd0);

    // Rotation through all owners, one grant per cycle; N=5 id sequence recorded alongside.
    cycle(4'b1111, rot5(m5), 1'b0); chk("s1_0", 32'(bus4.gnt), 32'b0001); ids5.push_back(m5.id);
    cycle(4'b1110, rot5(m5), 1'b0); chk("s1_1", 32'(bus4.gnt), 32'b0010); ids5.push_back(m5.id);
    cycle(4'b1100, rot5(m5), 1'b0); chk("s1_2", 32'(bus4.gnt), 32'b0100); ids5.push_back(m5.id);
    cycle(4'b1000, rot5(m5), 1'b0); chk("s1_3", 32'(bus4.gnt), 32'b1000); ids5.push_back(m5.id);
    cycle(4'b0001, rot5(m5), 1'b0); chk("s1_4", 32'(bus4.gnt), 32'b0001); ids5.push_back(m5.id);
    cycle(4'b0010, rot5(m5), 1'b0); chk("s2_own1", 32'(bus4.gnt), 32'b0010); ids5.push_back(m5.id);
    for (int i = 0; i < 6; i++)
      chk("n5_seq", 32'(dut5_ids(ids5, i)), 32'(i % 5));

    // Owner 1 releases with 0 and 3 pending: 3 is next after 1.
    cycle(4'b1011, 5'b00000, 1'b0); chk("s2_hold", 32'(bus4.gnt), 32'b0010);
    cycle(4'b1001, 5'b00000, 1'b0); chk("s2_gnt", 32'(bus4.gnt), 32'b1000);
    chk("s2_id", 32'(bus4.gnt_id), 32'd3);

    // Hold timeout scenario.
    cycle(4'b0000, 5'b00000, 1'b0); chk("idle_id", 32'(bus4.gnt_id), 32'd3);
    cycle(4'b0100, 5'b00000, 1'b0);
    cycle(4'b0100, 5'b00000, 1'b0);
    cycle(4'b0101, 5'b00000, 1'b0);
    cycle(4'b0101, 5'b00000, 1'b0); chk("s3_hold", 32'(bus4.gnt), 32'b0100);
    cycle(4'b0101, 5'b00000, 1'b0);
    chk("s3_gnt", 32'(bus4.gnt), TO_EN ? 32'b0001 : 32'b0100);
    chk("s3_to",  32'(bus4.timeout), 32'(TO_EN));
    cycle(4'b0101, 5'b00000, 1'b0); chk("s3_pulse", 32'(bus4.timeout), 32'd0);

    // Sole requester never times out.
    cycle(4'b0000, 5'b00000, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'b0100, 5'b00100, 1'b0);
    chk("s4_gnt", 32'(bus4.gnt), 32'b0100);

    // Reset mid-grant with 3 owning, then re-arbitration from req[0].
    cycle(4'b1000, 5'b00000, 1'b0); chk("s5_own3", 32'(bus4.gnt), 32'b1000);
    cycle(4'b1001, 5'b00000, 1'b1); chk("s5_rst", 32'(bus4.gnt), 32'd0);
    cycle(4'b1001, 5'b00000, 1'b0);
    chk("s5_gnt", 32'(bus4.gnt), 32'b0001);
    chk("s5_id",  32'(bus4.gnt_id), 32'd0);

    // Random phase: sticky requests with occasional reset.
    r4 = '0; r5 = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r5 = 5'($urandom);
      rs = ($urandom_range(0, 63) == 0);
      cycle(r4, r5, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  function automatic int dut5_ids(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
endmodule
